// File: rtl/led_hex_scanner.sv
// Eight-digit multiplexed hex display driver for the core's 27-bit debug word.
// The word is captured once per scan frame so a digit sweep never mixes old and new values.
module led_hex_scanner #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16,
  parameter int LZ_BLANK     = 1
) (
  input  logic        SYS_clk,
  input  logic        SYS_reset_n,
  input  logic [26:0] data_in,
  input  logic        freeze,
  output logic [7:0]  an_n,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic        frame_tick
);

  localparam int CNT_W = $clog2(REFRESH_DIV);

  typedef enum logic {
    PH_BLANK,
    PH_DRIVE
  } phase_t;

  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [26:0]      shadow;

  logic             slot_end;
  logic             frame_end;
  phase_t           phase;
  logic [31:0]      word;
  logic [31:0]      upper;
  logic [3:0]       nib;
  logic             lz_blank;
  logic [7:0]       next_an;
  logic [6:0]       next_seg;
  logic             next_dp;

  function automatic logic [6:0] hex_seg(input logic [3:0] v);
    case (v)
      4'h0: hex_seg = 7'h40;
      4'h1: hex_seg = 7'h79;
      4'h2: hex_seg = 7'h24;
      4'h3: hex_seg = 7'h30;
      4'h4: hex_seg = 7'h19;
      4'h5: hex_seg = 7'h12;
      4'h6: hex_seg = 7'h02;
      4'h7: hex_seg = 7'h78;
      4'h8: hex_seg = 7'h00;
      4'h9: hex_seg = 7'h10;
      4'hA: hex_seg = 7'h08;
      4'hB: hex_seg = 7'h03;
      4'hC: hex_seg = 7'h46;
      4'hD: hex_seg = 7'h21;
      4'hE: hex_seg = 7'h06;
      default: hex_seg = 7'h0E;
    endcase
  endfunction

  assign slot_end  = (cnt == CNT_W'(REFRESH_DIV - 1));
  assign frame_end = slot_end && (idx == 3'd7);

  always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
    if (!SYS_reset_n) begin
      cnt    <= '0;
      idx    <= 3'd0;
      shadow <= 27'd0;
    end else begin
      if (slot_end) begin
        cnt <= '0;
        idx <= idx + 3'd1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      if (frame_end && !freeze) begin
        shadow <= data_in;
      end
    end
  end

  // A digit is a leading zero when every nibble from it upward is zero.
  always_comb begin
    phase    = (cnt < CNT_W'(BLANK_CYCLES)) ? PH_BLANK : PH_DRIVE;
    word     = {5'b0, shadow};
    upper    = word >> {idx, 2'b00};
    nib      = upper[3:0];
    lz_blank = (LZ_BLANK != 0) && (idx != 3'd0) && (upper == 32'd0);
    next_an  = 8'hFF;
    next_seg = 7'h7F;
    next_dp  = 1'b1;
    if (phase == PH_DRIVE) begin
      next_an  = ~(8'b1 << idx);
      next_seg = lz_blank ? 7'h7F : hex_seg(nib);
      next_dp  = ~((idx == 3'd7) && freeze);
    end
  end

  always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
    if (!SYS_reset_n) begin
      an_n       <= 8'hFF;
      seg_n      <= 7'h7F;
      dp_n       <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      an_n       <= next_an;
      seg_n      <= next_seg;
      dp_n       <= next_dp;
      frame_tick <= frame_end;
    end
  end

endmodule

// File: tb/tb_led_hex_scanner.sv
// Bench for led_hex_scanner: directed and random steps checked against a cycle-count model
// of the scan (frame = 32 cycles with REFRESH_DIV=4, one blank cycle per slot).
module tb_led_hex_scanner;

  localparam int RDIV  = 4;
  localparam int BLANK = 1;
  localparam int FRAME = 8 * RDIV;

  logic        SYS_clk = 1'b0;
  logic        SYS_reset_n = 1'b1;
  logic [26:0] data_in = 27'd0;
  logic        freeze = 1'b0;
  logic [7:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic        frame_tick;

  int total = 0;
  int bad = 0;

  // Model state: edges since reset release and the word the display should be showing.
  int          edges = 0;
  logic [26:0] m_shadow = 27'd0;
  logic [6:0]  hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  led_hex_scanner #(.REFRESH_DIV(RDIV), .BLANK_CYCLES(BLANK), .LZ_BLANK(1)) dut (
    .SYS_clk     (SYS_clk),
    .SYS_reset_n (SYS_reset_n),
    .data_in     (data_in),
    .freeze      (freeze),
    .an_n        (an_n),
    .seg_n       (seg_n),
    .dp_n        (dp_n),
    .frame_tick  (frame_tick)
  );

  always #5 SYS_clk = ~SYS_clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h (edge %0d)", tag, obs, exp, edges);
    end
  endtask

  task automatic checkOutput(input logic [7:0] e_an, input logic [6:0] e_seg,
                             input logic e_dp, input logic e_ft);
    chk("an_n", an_n, e_an);
    chk("seg_n", {1'b0, seg_n}, {1'b0, e_seg});
    chk("dp_n", {7'b0, dp_n}, {7'b0, e_dp});
    chk("frame_tick", {7'b0, frame_tick}, {7'b0, e_ft});
  endtask

  // One clock edge: predict from the pre-edge view (shadow, inputs, cycle position) and compare.
  task automatic tick();
    int          pos, slot, ph;
    int unsigned rest;
    logic [7:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic        pre_freeze;
    logic [26:0] pre_data;
    pre_freeze = freeze;
    pre_data   = data_in;
    @(posedge SYS_clk);
    #1;
    edges++;
    pos  = (edges - 1) % FRAME;
    slot = pos / RDIV;
    ph   = pos % RDIV;
    e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1;
    if (ph >= BLANK) begin
      rest  = {5'b0, m_shadow} >> (4 * slot);
      e_an  = ~(8'(1) << slot);
      e_seg = (slot > 0 && rest == 0) ? 7'h7F : hex_tab[rest % 16];
      e_dp  = !(slot == 7 && pre_freeze);
    end
    checkOutput(e_an, e_seg, e_dp, (edges % FRAME) == 0);
    if (pos == FRAME - 1 && !pre_freeze) m_shadow = pre_data;
  endtask

  task automatic applyStimulus(input logic [26:0] d, input logic f, input int n);
    data_in = d;
    freeze  = f;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_to_frame();
    for (int i = 0; i < FRAME + 1; i++) begin
      if (edges % FRAME == 0 && i > 0) return;
      tick();
    end
  endtask

  task automatic release_reset();
    @(posedge SYS_clk);
    #1;
    SYS_reset_n = 1'b1;
    edges    = 0;
    m_shadow = 27'd0;
  endtask

  task automatic reset_mid_drive();
    int guard;
    guard = 0;
    while (((edges - 1) % RDIV) < BLANK && guard < 8) begin
      tick();
      guard++;
    end
    chk("drive_before_reset", {7'b0, an_n == 8'hFF}, 8'h00);
    #2;
    SYS_reset_n = 1'b0;
    #1;
    checkOutput(8'hFF, 7'h7F, 1'b1, 1'b0);
    release_reset();
    checkOutput(8'hFF, 7'h7F, 1'b1, 1'b0);
  endtask

  initial begin
    logic [26:0] d;
    int          k;
    $display("[TB] start");
    #1 SYS_reset_n = 1'b0;
    #2 checkOutput(8'hFF, 7'h7F, 1'b1, 1'b0);
    release_reset();

    // First frame after reset shows 0 on digit 0 with the rest blanked.
    applyStimulus(27'd0, 1'b0, 2 * FRAME);
    reset_mid_drive();
    applyStimulus(27'd0, 1'b0, FRAME);

    applyStimulus(27'h1234567, 1'b0, 0);
    run_to_frame();
    applyStimulus(27'h1234567, 1'b0, FRAME);

    applyStimulus(27'h1234567, 1'b0, 10);
    applyStimulus(27'h0000100, 1'b0, 0);
    run_to_frame();
    applyStimulus(27'h0000100, 1'b0, FRAME);

    applyStimulus(27'h7ABCDEF, 1'b1, 13);
    applyStimulus(27'h0F0F0F0, 1'b1, 2 * FRAME);
    applyStimulus(27'h0F0F0F0, 1'b0, 0);
    run_to_frame();
    applyStimulus(27'h0F0F0F0, 1'b0, FRAME);

    for (int f = 0; f < 8; f++) begin
      k = $urandom_range(0, 27);
      d = 27'(((32'h1 << k) - 32'h1) & $urandom);
      applyStimulus(d, 1'($urandom_range(0, 1)), $urandom_range(1, FRAME - 1));
      d = 27'($urandom);
      applyStimulus(d, 1'($urandom_range(0, 1)), FRAME);
    end

    reset_mid_drive();
    applyStimulus(27'h5A5A5A5, 1'b0, 2 * FRAME);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
